decode_issue_buffer: RTL
========================

// Module: decode_issue_buffer
// PURPOSE
//  Parametrised decode->execute issue stage; successor to the fixed single-entry decode/execute register.
//  Buffers up to DEPTH decoded instruction packets in a FIFO with valid/ready handshakes on both sides.
//  Holds the head packet while it has a load-use hazard, tracked by an internal load scoreboard of LOAD_LAT stages.
//  Sits between decode control/addr decoding and the execute stage.
// PARAMETERS
//  PAYLOAD_W  64  opaque decoded control+data bits (ALU ctrl, immediates, PC, reg data)
//  ADDR_WIDTH 4   register address width
//  NUM_SRC    3   source register ports per packet
//  DEPTH      4   FIFO entries, >=2, power of two
//  LOAD_LAT   1   cycles after a load issues before a dependent may issue, >=1
// PORTS
//  clk_i            in  1                   clock, rising edge
//  reset_i          in  1                   synchronous, active-high reset
//  flush_pipeline_i in  1                   squash all buffered and in-flight state
//  in_valid_i       in  1                   decode offers a packet
//  in_ready_o       out 1                   buffer accepts; push = in_valid_i & in_ready_o
//  in_payload_i     in  PAYLOAD_W           packet payload
//  in_src_addr_i    in  NUM_SRC*ADDR_WIDTH  source addrs, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//  in_src_used_i    in  NUM_SRC             port k is a real operand
//  in_dest_addr_i   in  ADDR_WIDTH          destination register
//  in_dest_we_i     in  1                   packet writes dest
//  in_mem_read_i    in  1                   packet is a load
//  out_valid_o      out 1                   head packet issuable
//  out_ready_i      in  1                   execute accepts; pop = out_valid_o & out_ready_i
//  out_payload_o    out PAYLOAD_W           head payload
//  out_src_addr_o   out NUM_SRC*ADDR_WIDTH  head source addrs (for forwarding)
//  out_dest_addr_o  out ADDR_WIDTH          head dest
//  out_dest_we_o    out 1                   head dest write enable
//  out_mem_read_o   out 1                   head is load
//  hazard_stall_o   out 1                   head present but blocked by load-use hazard
//  count_o          out $clog2(DEPTH+1)     occupancy
// BEHAVIOUR
//  Reset: FIFO empty, pointers 0, count_o=0, scoreboard cleared; out_valid_o=0, hazard_stall_o=0, in_ready_o=1.
//  Out data fields are don't-care while out_valid_o=0; the bench checks them only on pop.
//  in_ready_o = (count_o != DEPTH). It has no combinational path from out_ready_i; a full buffer refuses input even on a pop cycle.
//  Latency: a packet pushed in cycle t is at the head, and may issue, in cycle t+1 at the earliest. There is no bypass when empty.
//  Push and pop in the same cycle: count unchanged, both pointers advance, wrap modulo DEPTH.
//  Scoreboard: LOAD_LAT-stage shift register of {valid, dest_addr}.
//    - Stage 0 loads {pop & out_mem_read_o & out_dest_we_o, out_dest_addr_o} each cycle.
//    - Entries shift one stage per cycle, the last stage drops out.
//  hazard: some k has in_src_used_i-bit k set at the head and head src k equals a valid scoreboard dest.
//    - No register is exempt from the match.
//  out_valid_o = (count_o != 0) & ~hazard; hazard_stall_o = (count_o != 0) & hazard.
//  Load at t, LOAD_LAT=1: a dependent head cannot issue at t+1 and issues at t+2 (one bubble); LOAD_LAT=N gives N bubbles.
//  A head that is not a load, or not dependent, issues back-to-back every cycle while out_ready_i=1.
//  out_* fields stay stable while out_valid_o=1 and out_ready_i=0.
//  flush_pipeline_i has priority over everything in that cycle:
//    - next cycle count=0, scoreboard cleared, pointers reset to 0;
//    - a same-cycle push is dropped and a same-cycle pop does not update the scoreboard.
//  reset_i mid-operation is equivalent to flush_pipeline_i plus the reset values above.
// TESTING
//  1 Reset, then 4 pushes of payloads 0x1..0x4 with out_ready_i=0 -> count_o=4, in_ready_o=0; a 5th push with payload 0x5 is not accepted.
//  2 DEPTH=4: continuous push/pop for 10 cycles -> payloads pop in order 0x1..0xA, count_o stays 1, pointers wrap cleanly.
//  3 LDR r3 (mem_read, we, dest 3) then ADD src0=r3 -> ADD stalls 1 cycle, hazard_stall_o=1 for that cycle; with LOAD_LAT=2 it stalls 2 cycles.
//  4 LDR r3 then ADD using r4, and LDR r3 then ADD with r3 on a port whose src_used bit is 0 -> no stall in either case.
//  5 FIFO holds 3 entries, a load issued last cycle, flush_pipeline_i=1 with in_valid_i=1 -> next cycle count_o=0, scoreboard empty, pushed packet lost.
//  6 Random valid/ready on both sides, 10k cycles -> scoreboard model matches issue order and stalls; no loss or duplication.

Source files
------------

// File: rtl/decode_issue_buffer.sv
// Decode->execute issue FIFO with valid/ready on both sides and a
// load scoreboard that holds a dependent head until load data is ready.
module decode_issue_buffer #(
    parameter int PAYLOAD_W  = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_SRC    = 3,
    parameter int DEPTH      = 4,
    parameter int LOAD_LAT   = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          flush_pipeline_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [PAYLOAD_W-1:0]          in_payload_i,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] in_src_addr_i,
    input  logic [NUM_SRC-1:0]            in_src_used_i,
    input  logic [ADDR_WIDTH-1:0]         in_dest_addr_i,
    input  logic                          in_dest_we_i,
    input  logic                          in_mem_read_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [PAYLOAD_W-1:0]          out_payload_o,
    output logic [NUM_SRC*ADDR_WIDTH-1:0] out_src_addr_o,
    output logic [ADDR_WIDTH-1:0]         out_dest_addr_o,
    output logic                          out_dest_we_o,
    output logic                          out_mem_read_o,
    output logic                          hazard_stall_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = NUM_SRC * ADDR_WIDTH;

    logic [PAYLOAD_W-1:0]  mem_payload [DEPTH];
    logic [SW-1:0]         mem_src     [DEPTH];
    logic [NUM_SRC-1:0]    mem_used    [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_dest    [DEPTH];
    logic [DEPTH-1:0]      mem_we;
    logic [DEPTH-1:0]      mem_rd;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [LOAD_LAT-1:0]   sb_valid;
    logic [ADDR_WIDTH-1:0] sb_dest [LOAD_LAT];

    logic                  not_empty;
    logic                  hazard;
    logic                  push;
    logic                  pop;
    logic [NUM_SRC-1:0]    head_used;

    assign not_empty       = (count != '0);
    assign in_ready_o      = (count != CW'(DEPTH));
    assign out_valid_o     = not_empty & ~hazard;
    assign hazard_stall_o  = not_empty & hazard;
    assign count_o         = count;

    assign out_payload_o   = mem_payload[rd_ptr];
    assign out_src_addr_o  = mem_src[rd_ptr];
    assign out_dest_addr_o = mem_dest[rd_ptr];
    assign out_dest_we_o   = mem_we[rd_ptr];
    assign out_mem_read_o  = mem_rd[rd_ptr];
    assign head_used       = mem_used[rd_ptr];

    // A flush squashes the push and keeps the pop out of the scoreboard.
    assign push = in_valid_i & in_ready_o & ~flush_pipeline_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_pipeline_i;

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int s = 0; s < LOAD_LAT; s++) begin
                if (head_used[k] && sb_valid[s] &&
                    out_src_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH] == sb_dest[s]) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_payload[wr_ptr] <= in_payload_i;
            mem_src[wr_ptr]     <= in_src_addr_i;
            mem_used[wr_ptr]    <= in_src_used_i;
            mem_dest[wr_ptr]    <= in_dest_addr_i;
            mem_we[wr_ptr]      <= in_dest_we_i;
            mem_rd[wr_ptr]      <= in_mem_read_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_pipeline_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_pipeline_i) begin
            sb_valid <= '0;
        end else begin
            for (int s = LOAD_LAT - 1; s > 0; s--) begin
                sb_valid[s] <= sb_valid[s-1];
                sb_dest[s]  <= sb_dest[s-1];
            end
            sb_valid[0] <= pop & out_mem_read_o & out_dest_we_o;
            sb_dest[0]  <= out_dest_addr_o;
        end
    end
endmodule
